// File: rtl/sincos_pkg.sv
// Shared types for the sine-core scheduler: tag layout, FSM states, cos phase offset.
// The tag carries a cos bit only when SINCOS_SCHED_PAIR_EN is defined.
package sincos_pkg;

  localparam logic [31:0] COS_OFFSET = 32'h4000_0000;

  // Sized for the largest supported requester count (8); instances use the low bits.
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
`ifdef SINCOS_SCHED_PAIR_EN
    logic                cos;
`endif
  } tag_t;

  typedef enum logic {
    ISSUE = 1'b0,
    COS   = 1'b1
  } state_e;

endpackage

// File: rtl/sincos_sched_if.sv
// Requester-side bundle of the scheduler: request handshakes and response strobes.
interface sincos_sched_if #(
  parameter int NUM_REQ      = 4,
  parameter int OUTPUT_WIDTH = 32
);
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ*32-1:0]   req_phase_i;
  logic [NUM_REQ-1:0]      req_pair_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [NUM_REQ-1:0]      rsp_valid_o;
  logic [OUTPUT_WIDTH-1:0] rsp_data_o;
  logic                    rsp_cos_o;

  modport slave (
    input  req_valid_i, req_phase_i, req_pair_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_cos_o
  );

  modport master (
    output req_valid_i, req_phase_i, req_pair_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_cos_o
  );
endinterface

// File: rtl/sincos_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);
  logic [IDW:0] pos;

  always_comb begin
    pos     = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    grant_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NUM_REQ)) pos = pos - (IDW+1)'(NUM_REQ);
      if (!any_o && req_i[pos[IDW-1:0]]) begin
        any_o = 1'b1;
        idx_o = pos[IDW-1:0];
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/sincos_sched.sv
// Round-robin scheduler sharing one fixed-latency sine core among NUM_REQ requesters.
// Define SINCOS_SCHED_PAIR_EN to enable sin/cos pair issue (COS state, req_pair_i, rsp_cos_o).
module sincos_sched
  import sincos_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int OUTPUT_WIDTH = 32,
  parameter int CORE_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  sincos_sched_if.slave           req_if,
  output logic [31:0]             core_phase_o,
  output logic                    core_valid_o,
  input  logic [OUTPUT_WIDTH-1:0] core_result_i,
  input  logic                    core_valid_i,
  output logic                    err_o
);
  localparam int IDW = $clog2(NUM_REQ);

  state_e                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [31:0]             phase_q, phase_d;
  logic                    core_valid_q, core_valid_d;
  tag_t                    issue_tag_q, issue_tag_d;
  tag_t                    tag_out;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [OUTPUT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_cos_q, rsp_cos_d;
  logic                    err_q, err_d;
`ifdef SINCOS_SCHED_PAIR_EN
  logic [IDW-1:0]          pair_id_q, pair_id_d;
  logic [31:0]             pair_phase_q, pair_phase_d;
`endif

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [31:0]        grant_phase;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_if.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign grant_phase        = req_if.req_phase_i[32*int'(grant_idx) +: 32];
  assign req_if.req_ready_o = (state_q == ISSUE) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    phase_d      = phase_q;
    core_valid_d = 1'b0;
    issue_tag_d  = '0;
`ifdef SINCOS_SCHED_PAIR_EN
    pair_id_d    = pair_id_q;
    pair_phase_d = pair_phase_q;
`endif
    case (state_q)
      ISSUE: begin
        if (grant_any) begin
          phase_d           = grant_phase;
          core_valid_d      = 1'b1;
          issue_tag_d.valid = 1'b1;
          issue_tag_d.id    = TAG_ID_W'(grant_idx);
          ptr_d             = (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
`ifdef SINCOS_SCHED_PAIR_EN
          if (req_if.req_pair_i[grant_idx]) begin
            pair_phase_d = grant_phase;
            pair_id_d    = grant_idx;
            state_d      = COS;
          end
`endif
        end
      end
`ifdef SINCOS_SCHED_PAIR_EN
      COS: begin
        // Quarter-turn advance turns the sine core into a cosine; wraps mod 2^32.
        phase_d           = pair_phase_q + COS_OFFSET;
        core_valid_d      = 1'b1;
        issue_tag_d.valid = 1'b1;
        issue_tag_d.id    = TAG_ID_W'(pair_id_q);
        issue_tag_d.cos   = 1'b1;
        state_d           = ISSUE;
      end
`endif
      default: state_d = ISSUE;
    endcase
  end

  // issue_tag_q is aligned with core_valid_o; the chain adds CORE_LAT more cycles.
  for (genvar i = 0; i < CORE_LAT; i++) begin : g_tag
    tag_t stage_q;
    if (i == 0) begin : g_head
      always_ff @(posedge clk or negedge resetn)
        if (!resetn) stage_q <= '0;
        else         stage_q <= issue_tag_q;
    end else begin : g_body
      always_ff @(posedge clk or negedge resetn)
        if (!resetn) stage_q <= '0;
        else         stage_q <= g_tag[i-1].stage_q;
    end
  end

  assign tag_out = g_tag[CORE_LAT-1].stage_q;

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_cos_d   = rsp_cos_q;
    err_d       = err_q;
    if (tag_out.valid) begin
      rsp_valid_d[tag_out.id[IDW-1:0]] = 1'b1;
      rsp_data_d                       = core_result_i;
`ifdef SINCOS_SCHED_PAIR_EN
      rsp_cos_d                        = tag_out.cos;
`else
      rsp_cos_d                        = 1'b0;
`endif
    end
    if (tag_out.valid != core_valid_i) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ISSUE;
      ptr_q        <= '0;
      phase_q      <= '0;
      core_valid_q <= 1'b0;
      issue_tag_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_cos_q    <= 1'b0;
      err_q        <= 1'b0;
`ifdef SINCOS_SCHED_PAIR_EN
      pair_id_q    <= '0;
      pair_phase_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      phase_q      <= phase_d;
      core_valid_q <= core_valid_d;
      issue_tag_q  <= issue_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_cos_q    <= rsp_cos_d;
      err_q        <= err_d;
`ifdef SINCOS_SCHED_PAIR_EN
      pair_id_q    <= pair_id_d;
      pair_phase_q <= pair_phase_d;
`endif
    end
  end

  assign core_phase_o       = phase_q;
  assign core_valid_o       = core_valid_q;
  assign req_if.rsp_valid_o = rsp_valid_q;
  assign req_if.rsp_data_o  = rsp_data_q;
  assign req_if.rsp_cos_o   = rsp_cos_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_sincos_sched.sv
// Self-checking bench for sincos_sched: reference arbiter model plus phase/response scoreboards.
module tb_sincos_sched;
  import sincos_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int OW       = 32;
  localparam int CORE_LAT = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sincos_sched_if #(.NUM_REQ(NUM_REQ), .OUTPUT_WIDTH(OW)) rif ();

  logic [31:0] core_phase_o;
  logic        core_valid_o;
  logic [OW-1:0] core_result_i;
  logic        core_valid_i;
  logic        err_o;

  sincos_sched #(.NUM_REQ(NUM_REQ), .OUTPUT_WIDTH(OW), .CORE_LAT(CORE_LAT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_if        (rif.slave),
    .core_phase_o  (core_phase_o),
    .core_valid_o  (core_valid_o),
    .core_result_i (core_result_i),
    .core_valid_i  (core_valid_i),
    .err_o         (err_o)
  );

  function automatic logic [31:0] core_f(input logic [31:0] p);
    return p ^ 32'hA5A5_5A5A;
  endfunction

  // Core model: fixed latency pipe, reset by resetn, can drop one valid on request.
  logic [CORE_LAT-1:0] cm_v;
  logic [31:0]         cm_p [CORE_LAT];
  int drop_req  = 0;
  int drop_done = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cm_v <= '0;
      for (int i = 0; i < CORE_LAT; i++) cm_p[i] <= '0;
    end else begin
      cm_v[0] <= core_valid_o && (drop_req == drop_done);
      if (core_valid_o && (drop_req != drop_done)) drop_done <= drop_done + 1;
      cm_p[0] <= core_phase_o;
      for (int i = 1; i < CORE_LAT; i++) begin
        cm_v[i] <= cm_v[i-1];
        cm_p[i] <= cm_p[i-1];
      end
    end
  end

  assign core_valid_i  = cm_v[CORE_LAT-1];
  assign core_result_i = core_f(cm_p[CORE_LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic [31:0] phase; int cyc; } ph_exp_t;
  typedef struct packed { int id; logic [31:0] data; logic cos; int cyc; } rsp_exp_t;
  ph_exp_t  ph_q[$];
  rsp_exp_t rsp_q[$];
  ph_exp_t  pe;
  rsp_exp_t re;

  int          model_ptr = 0;
  bit          model_cos = 1'b0;
  int          model_pair_id = 0;
  logic [31:0] model_pair_phase = '0;
  int          gcnt [NUM_REQ];

  always @(negedge clk) begin
    if (resetn) begin
      if (core_valid_o) begin
        checks++;
        if (ph_q.size() == 0) begin
          failures++;
          $display("FAIL core_issue unexpected cyc=%0d phase=%h", cyc, core_phase_o);
        end else begin
          pe = ph_q.pop_front();
          if (core_phase_o !== pe.phase || cyc != pe.cyc) begin
            failures++;
            $display("FAIL core_issue got phase=%h cyc=%0d exp phase=%h cyc=%0d",
                     core_phase_o, cyc, pe.phase, pe.cyc);
          end
        end
      end
      if (rif.rsp_valid_o !== '0) begin
        checks++;
        if (rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp unexpected cyc=%0d valid=%b", cyc, rif.rsp_valid_o);
        end else begin
          re = rsp_q.pop_front();
          if (rif.rsp_valid_o !== (NUM_REQ'(1) << re.id) || rif.rsp_data_o !== re.data ||
              rif.rsp_cos_o !== re.cos || cyc != re.cyc) begin
            failures++;
            $display("FAIL rsp got valid=%b data=%h cos=%b cyc=%0d exp id=%0d data=%h cos=%b cyc=%0d",
                     rif.rsp_valid_o, rif.rsp_data_o, rif.rsp_cos_o, cyc,
                     re.id, re.data, re.cos, re.cyc);
          end
        end
      end
    end
  end

  // Called at a negedge; drives one cycle of requests and returns at the next negedge.
  task automatic drive_cycle(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] pr);
    logic [NUM_REQ-1:0] exp_g;
    logic [31:0]        ph;
    int                 g;
    int                 p;
    rif.req_valid_i = v;
    rif.req_pair_i  = pr;
    #1;
    exp_g = '0;
    g     = -1;
    if (model_cos) begin
      ph = model_pair_phase + 32'h4000_0000;
      ph_q.push_back('{phase: ph, cyc: cyc + 1});
      rsp_q.push_back('{id: model_pair_id, data: core_f(ph), cos: 1'b1, cyc: cyc + 2 + CORE_LAT});
      model_cos = 1'b0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        p = (model_ptr + k) % NUM_REQ;
        if (g < 0 && v[p]) g = p;
      end
      if (g >= 0) begin
        exp_g[g] = 1'b1;
        ph = rif.req_phase_i[32*g +: 32];
        ph_q.push_back('{phase: ph, cyc: cyc + 1});
        rsp_q.push_back('{id: g, data: core_f(ph), cos: 1'b0, cyc: cyc + 2 + CORE_LAT});
        model_ptr = (g + 1) % NUM_REQ;
`ifdef SINCOS_SCHED_PAIR_EN
        if (pr[g]) begin
          model_cos        = 1'b1;
          model_pair_phase = ph;
          model_pair_id    = g;
        end
`endif
      end
    end
    for (int i = 0; i < NUM_REQ; i++) if (rif.req_ready_o[i] === 1'b1) gcnt[i]++;
    checks++;
    if (rif.req_ready_o !== exp_g) begin
      failures++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, rif.req_ready_o, exp_g);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (CORE_LAT + 4) drive_cycle('0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (core_valid_o !== 1'b0 || core_phase_o !== 32'h0 || rif.rsp_valid_o !== '0 ||
        rif.rsp_data_o !== '0 || rif.rsp_cos_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s got cv=%b ph=%h rv=%b rd=%h rc=%b err=%b exp all zero", tag,
               core_valid_o, core_phase_o, rif.rsp_valid_o, rif.rsp_data_o, rif.rsp_cos_o, err_o);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset_hold");
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
    checks++;
    if (rif.req_ready_o !== '0) begin
      failures++;
      $display("FAIL idle_ready got=%b exp=0", rif.req_ready_o);
    end
  endtask

  task automatic test_single();
    int c0;
    rif.req_phase_i[32 +: 32] = 32'h2000_0000;
    c0 = cyc;
    drive_cycle(4'b0010, 4'b0000);
    checks++;
    if (core_valid_o !== 1'b1 || core_phase_o !== 32'h2000_0000 || cyc != c0 + 1) begin
      failures++;
      $display("FAIL single_issue got cv=%b ph=%h exp cv=1 ph=20000000", core_valid_o, core_phase_o);
    end
    for (int k = 2; k <= 4; k++) begin
      drive_cycle('0, '0);
      checks++;
      if (k < 4 && rif.rsp_valid_o !== '0) begin
        failures++;
        $display("FAIL single_early k=%0d got=%b exp=0", k, rif.rsp_valid_o);
      end else if (k == 4 && (rif.rsp_valid_o !== 4'b0010 || rif.rsp_cos_o !== 1'b0 ||
                              rif.rsp_data_o !== core_f(32'h2000_0000))) begin
        failures++;
        $display("FAIL single_rsp got v=%b d=%h c=%b exp v=0010 d=%h c=0",
                 rif.rsp_valid_o, rif.rsp_data_o, rif.rsp_cos_o, core_f(32'h2000_0000));
      end
    end
    drain();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < NUM_REQ; i++) rif.req_phase_i[32*i +: 32] = 32'h1111_0000 * (i + 1) + 32'h42;
    drive_cycle(4'b1000, 4'b0000);
    for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
    repeat (12) drive_cycle(4'b1111, 4'b0000);
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (gcnt[i] != 3) begin
        failures++;
        $display("FAIL rr_count req=%0d got=%0d exp=3", i, gcnt[i]);
      end
    end
    drain();
  endtask

  task automatic test_pair();
    rif.req_phase_i[64 +: 32] = 32'hC000_0000;
    drive_cycle(4'b0100, 4'b0100);
    drive_cycle(4'b1111, 4'b0000);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NUM_REQ; i++) rif.req_phase_i[32*i +: 32] = $urandom;
      drive_cycle(NUM_REQ'($urandom_range(0, 15)), NUM_REQ'($urandom_range(0, 15)));
    end
    drain();
  endtask

  task automatic test_err();
    int c0;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_pre got=%b exp=0", err_o);
    end
    rif.req_phase_i[0 +: 32] = 32'h0123_4567;
    drop_req = drop_req + 1;
    c0 = cyc;
    drive_cycle(4'b0001, 4'b0000);
    while (cyc < c0 + 3) drive_cycle('0, '0);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_early got=%b exp=0", err_o);
    end
    drive_cycle('0, '0);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_rise got=%b exp=1", err_o);
    end
    repeat (4) drive_cycle(4'b1111, 4'b0000);
    drain();
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err_o);
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(4'b0001, 4'b0000);
    drive_cycle(4'b0010, 4'b0000);
    drive_cycle(4'b0100, 4'b0000);
    rif.req_valid_i = '0;
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("midreset_hold");
    ph_q.delete();
    rsp_q.delete();
    model_ptr = 0;
    model_cos = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_cycle('0, '0);
      checks++;
      if (rif.rsp_valid_o !== '0) begin
        failures++;
        $display("FAIL midreset_stale k=%0d got=%b exp=0", k, rif.rsp_valid_o);
      end
    end
    drive_cycle(4'b1111, 4'b0000);
    drain();
  endtask

  initial begin
    rif.req_valid_i = '0;
    rif.req_pair_i  = '0;
    rif.req_phase_i = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_pair();
    test_back_to_back();
    test_err();
    test_mid_reset();
    checks++;
    if (ph_q.size() != 0 || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover got ph=%0d rsp=%0d exp 0 0", ph_q.size(), rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
